// File: rtl/uart_bus_bridge_pkg.sv
// Shared constants for the UART-to-bus debug bridge:
// FSM state codes and the serial command/response bytes.
package uart_bus_bridge_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_CMD     = 3'd1;
  localparam state_t S_ADDR    = 3'd2;
  localparam state_t S_WDATA   = 3'd3;
  localparam state_t S_GRANT   = 3'd4;
  localparam state_t S_ACCESS  = 3'd5;
  localparam state_t S_CAPTURE = 3'd6;
  localparam state_t S_RESP    = 3'd7;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

endpackage

// File: rtl/uart_bridge_rx.sv
// 8N1 byte receiver: two-flop synchroniser, glitch-filtered start bit,
// LSB-first shifter and stop-bit framing check.
module uart_bridge_rx #(
  parameter int CPB = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_frame_err
);
  import uart_bus_bridge_pkg::*;

  localparam int CW = $clog2(CPB + 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  // sync[1] is the synchronised line, sync[2] its previous value
  logic [2:0]    sync;
  logic [1:0]    rstate;
  logic [CW-1:0] cnt;
  logic [2:0]    nbit;
  logic [7:0]    sh;
  logic          line;
  logic          fall;

  assign line    = sync[1];
  assign fall    = sync[2] & ~sync[1];
  assign rx_byte = sh;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync         <= 3'b111;
      rstate       <= RX_IDLE;
      cnt          <= '0;
      nbit         <= '0;
      sh           <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      sync         <= {sync[1:0], rx};
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rstate)
        RX_IDLE: begin
          cnt <= '0;
          if (fall) rstate <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt    <= '0;
            nbit   <= '0;
            rstate <= line ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt  <= '0;
            sh   <= {line, sh[7:1]};
            nbit <= nbit + 3'd1;
            if (nbit == 3'd7) rstate <= RX_STOP;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          if (cnt == FULL) begin
            cnt          <= '0;
            rx_valid     <= line;
            rx_frame_err <= ~line;
            rstate       <= RX_IDLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART-to-bus debug bridge: serial command frames in, 32-bit accesses out.
// Optional inter-byte timeout is enabled by defining UART_BRIDGE_TIMEOUT_EN.
module uart_bus_bridge #(
  parameter int CLOCK_FREQ     = 50000000,
  parameter int BAUD_RATE      = 9600,
  parameter int TIMEOUT_CYCLES = 16 * (CLOCK_FREQ / BAUD_RATE) * 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [31:0] bus_rw_address,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_write_mask,
  output logic        bus_write_request,
  input  logic [31:0] bus_rdata,
  input  logic        bus_grant,
  output logic        bridge_busy
);
  import uart_bus_bridge_pkg::*;

  localparam int CPB = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state;
  state_t        state_n;
  logic [7:0]    cmd;
  logic [1:0]    bcnt;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   resp_buf;
  logic [1:0]    resp_left;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          rx_err;
  logic          is_write;
  logic          is_cmd;
  logic          tx_load;
  logic [7:0]    tx_byte;
  logic [9:0]    tx_sh;
  logic [3:0]    tx_bits;
  logic [CW-1:0] tx_cnt;
  logic          tx_busy;
  logic          acc;
  logic          wr_acc;
  logic          tmo_hit;

  uart_bridge_rx #(.CPB(CPB)) u_rx (
    .clock        (clock),
    .reset        (reset),
    .rx           (uart_rx),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .rx_frame_err (rx_err)
  );

`ifdef UART_BRIDGE_TIMEOUT_EN
  logic [31:0] tmo;
  assign tmo_hit = (tmo == 32'(TIMEOUT_CYCLES));
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      tmo <= '0;
    else if ((state == S_ADDR || state == S_WDATA) && !rx_valid && !tmo_hit)
      tmo <= tmo + 32'd1;
    else
      tmo <= '0;
  end
`else
  // a partial frame waits for its next byte forever
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  assign is_write = (cmd == CMD_WRITE);
  assign is_cmd   = is_write || (cmd == CMD_READ);
  assign tx_busy  = (tx_bits != 4'd0);

  always_comb begin
    state_n = state;
    tx_load = 1'b0;
    tx_byte = RSP_NAK;
    unique case (state)
      S_IDLE: begin
        if (rx_err) begin
          state_n = S_RESP;
          tx_load = 1'b1;
        end else if (rx_valid) begin
          state_n = S_CMD;
        end
      end
      S_CMD: begin
        if (is_cmd) begin
          state_n = S_ADDR;
        end else begin
          state_n = S_RESP;
          tx_load = 1'b1;
        end
      end
      S_ADDR, S_WDATA: begin
        if (rx_err || tmo_hit) begin
          state_n = S_RESP;
          tx_load = 1'b1;
        end else if (rx_valid && bcnt == 2'd3) begin
          state_n = (state == S_ADDR && is_write) ? S_WDATA : S_GRANT;
        end
      end
      S_GRANT: begin
        if (bus_grant) state_n = S_ACCESS;
      end
      S_ACCESS: begin
        if (is_write) begin
          state_n = S_RESP;
          tx_load = 1'b1;
          tx_byte = RSP_ACK;
        end else begin
          state_n = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_n = S_RESP;
        tx_load = 1'b1;
        tx_byte = bus_rdata[7:0];
      end
      default: begin
        if (!tx_busy) begin
          if (resp_left == 2'd0) begin
            state_n = S_IDLE;
          end else begin
            tx_load = 1'b1;
            tx_byte = resp_buf[7:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cmd       <= '0;
      bcnt      <= '0;
      addr      <= '0;
      wdata     <= '0;
      resp_buf  <= '0;
      resp_left <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && rx_valid) cmd <= rx_byte;
      if (state == S_CMD) bcnt <= '0;
      if (state == S_ADDR && rx_valid) begin
        addr <= {rx_byte, addr[31:8]};
        bcnt <= bcnt + 2'd1;
      end
      if (state == S_WDATA && rx_valid) begin
        wdata <= {rx_byte, wdata[31:8]};
        bcnt  <= bcnt + 2'd1;
      end
      if (state == S_CAPTURE) begin
        resp_buf  <= {8'h00, bus_rdata[31:8]};
        resp_left <= 2'd3;
      end else if (state == S_RESP && tx_load) begin
        resp_buf  <= {8'h00, resp_buf[31:8]};
        resp_left <= resp_left - 2'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_sh   <= '1;
      tx_bits <= '0;
      tx_cnt  <= '0;
    end else if (tx_load) begin
      tx_sh   <= {1'b1, tx_byte, 1'b0};
      tx_bits <= 4'd10;
      tx_cnt  <= '0;
    end else if (tx_busy) begin
      if (tx_cnt == FULL) begin
        tx_cnt  <= '0;
        tx_sh   <= {1'b1, tx_sh[9:1]};
        tx_bits <= tx_bits - 4'd1;
      end else begin
        tx_cnt <= tx_cnt + ONE;
      end
    end
  end

  assign acc    = (state == S_ACCESS) || (state == S_CAPTURE);
  assign wr_acc = (state == S_ACCESS) && is_write;

  assign uart_tx           = tx_sh[0];
  assign bus_rw_address    = acc ? addr : '0;
  assign bus_wdata         = wr_acc ? wdata : '0;
  assign bus_write_mask    = wr_acc ? 4'hF : 4'h0;
  assign bus_write_request = wr_acc;
  assign bridge_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: frame vector table plus
// hand-written grant-stall, framing-error, glitch and reset sequences.
module tb_uart_bus_bridge;

  localparam int CPB = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic [31:0] bus_rw_address;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_write_mask;
  logic        bus_write_request;
  logic [31:0] bus_rdata = '0;
  logic        bus_grant = 1'b0;
  logic        bridge_busy;

  uart_bus_bridge #(
    .CLOCK_FREQ (160),
    .BAUD_RATE  (10)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .uart_rx           (uart_rx),
    .uart_tx           (uart_tx),
    .bus_rw_address    (bus_rw_address),
    .bus_wdata         (bus_wdata),
    .bus_write_mask    (bus_write_mask),
    .bus_write_request (bus_write_request),
    .bus_rdata         (bus_rdata),
    .bus_grant         (bus_grant),
    .bridge_busy       (bridge_busy)
  );

  always #5 clock = ~clock;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  int          wr_n = 0;
  int          act_n = 0;
  int          act_cyc = 0;
  logic [31:0] w_addr = '0;
  logic [31:0] w_data = '0;
  logic [3:0]  w_mask = '0;
  logic [31:0] a_addr = '0;

  always @(negedge clock) begin
    if (reset) begin
      if (bus_write_request) begin
        wr_n   <= wr_n + 1;
        w_addr <= bus_rw_address;
        w_data <= bus_wdata;
        w_mask <= bus_write_mask;
      end
      if (bus_rw_address != 0 || bus_wdata != 0 ||
          bus_write_mask != 0 || bus_write_request) begin
        act_n   <= act_n + 1;
        act_cyc <= cyc;
        a_addr  <= bus_rw_address;
      end
    end
  end

  logic [7:0] rxq[$];
  int         txc[$];

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clock);
      if (reset && uart_tx === 1'b0) begin
        txc.push_back(cyc);
        repeat (CPB / 2) @(negedge clock);
        b = '0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clock);
        rxq.push_back(b);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clock);
    uart_rx = 1'b1;
    if (!stop) repeat (CPB) @(negedge clock);
  endtask

  task automatic wait_resp(input int n, input int budget);
    int t;
    t = 0;
    while (rxq.size() < n && t < budget) begin
      @(negedge clock);
      t++;
    end
    nchk++;
    if (rxq.size() < n) begin
      nerr++;
      $display("FAIL resp_count: got %0d want %0d", rxq.size(), n);
    end
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (bridge_busy && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk(name, 32'(bridge_busy), 32'd0);
  endtask

  function automatic logic [31:0] qbyte(input int j);
    return (rxq.size() > j) ? 32'(rxq[j]) : 32'hFFFF_FFFF;
  endfunction

  typedef struct {
    logic [7:0]  frame [9];
    int          len;
    logic [31:0] rdata;
    logic [7:0]  resp [4];
    int          rlen;
    int          wr;
    int          act;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t v [5];

  initial begin
    int wr0;
    int act0;

    v[0].frame = '{8'h57, 8'h00, 8'h01, 8'h00, 8'h00,
                   8'hEF, 8'hBE, 8'hAD, 8'hDE};
    v[0].len = 9; v[0].rdata = 32'h0;
    v[0].resp = '{8'h06, 8'h00, 8'h00, 8'h00}; v[0].rlen = 1;
    v[0].wr = 1; v[0].act = 1;
    v[0].addr = 32'h0000_0100; v[0].wdata = 32'hDEAD_BEEF;

    v[1].frame = '{8'h52, 8'h04, 8'h01, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00};
    v[1].len = 5; v[1].rdata = 32'h1234_5678;
    v[1].resp = '{8'h78, 8'h56, 8'h34, 8'h12}; v[1].rlen = 4;
    v[1].wr = 0; v[1].act = 2;
    v[1].addr = 32'h0000_0104; v[1].wdata = 32'h0;

    v[2].frame = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00};
    v[2].len = 1; v[2].rdata = 32'hFFFF_FFFF;
    v[2].resp = '{8'h15, 8'h00, 8'h00, 8'h00}; v[2].rlen = 1;
    v[2].wr = 0; v[2].act = 0;
    v[2].addr = 32'h0; v[2].wdata = 32'h0;

    v[3].frame = '{8'h57, 8'hFC, 8'hFF, 8'hFF, 8'hFF,
                   8'h01, 8'h00, 8'h00, 8'h80};
    v[3].len = 9; v[3].rdata = 32'h0;
    v[3].resp = '{8'h06, 8'h00, 8'h00, 8'h00}; v[3].rlen = 1;
    v[3].wr = 1; v[3].act = 1;
    v[3].addr = 32'hFFFF_FFFC; v[3].wdata = 32'h8000_0001;

    v[4].frame = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00};
    v[4].len = 5; v[4].rdata = 32'hA5A5_0F0F;
    v[4].resp = '{8'h0F, 8'h0F, 8'hA5, 8'hA5}; v[4].rlen = 4;
    v[4].wr = 0; v[4].act = 2;
    v[4].addr = 32'h0000_0040; v[4].wdata = 32'h0;

    repeat (3) @(negedge clock);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_addr", bus_rw_address, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_mask", 32'(bus_write_mask), 32'd0);
    chk("rst_wreq", 32'(bus_write_request), 32'd0);
    chk("rst_busy", 32'(bridge_busy), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("idle_tx", 32'(uart_tx), 32'd1);
    chk("idle_busy", 32'(bridge_busy), 32'd0);

    for (int k = 0; k < 5; k++) begin
      bus_rdata = v[k].rdata;
      bus_grant = 1'b1;
      wr0 = wr_n;
      act0 = act_n;
      rxq.delete();
      txc.delete();
      for (int j = 0; j < v[k].len; j++) send_byte(v[k].frame[j], 1'b1);
      wait_resp(v[k].rlen, 400 + 200 * v[k].rlen);
      for (int j = 0; j < v[k].rlen; j++)
        chk($sformatf("v%0d_resp%0d", k, j), qbyte(j), 32'(v[k].resp[j]));
      wait_idle($sformatf("v%0d_busy_low", k));
      chk($sformatf("v%0d_nresp", k), 32'(rxq.size()), 32'(v[k].rlen));
      chk($sformatf("v%0d_wr_cnt", k), 32'(wr_n - wr0), 32'(v[k].wr));
      chk($sformatf("v%0d_act_cyc", k), 32'(act_n - act0), 32'(v[k].act));
      if (v[k].wr != 0) begin
        chk($sformatf("v%0d_waddr", k), w_addr, v[k].addr);
        chk($sformatf("v%0d_wdata", k), w_data, v[k].wdata);
        chk($sformatf("v%0d_wmask", k), 32'(w_mask), 32'hF);
      end
      if (v[k].act == 2)
        chk($sformatf("v%0d_raddr", k), a_addr, v[k].addr);
      if (v[k].act != 0 && txc.size() > 0)
        chk($sformatf("v%0d_tx_lat", k), 32'(txc[0] - act_cyc), 32'd1);
    end

    // grant withheld: no bus activity until grant rises
    bus_grant = 1'b0;
    wr0 = wr_n;
    act0 = act_n;
    rxq.delete();
    txc.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h11, 1'b1);
    repeat (100) @(negedge clock);
    chk("gw_act", 32'(act_n - act0), 32'd0);
    chk("gw_busy", 32'(bridge_busy), 32'd1);
    chk("gw_tx_idle", 32'(uart_tx), 32'd1);
    bus_grant = 1'b1;
    @(negedge clock);
    chk("gw_wreq", 32'(bus_write_request), 32'd1);
    chk("gw_addr", bus_rw_address, 32'h0000_0010);
    chk("gw_wdata", bus_wdata, 32'h1122_3344);
    chk("gw_mask", 32'(bus_write_mask), 32'hF);
    @(negedge clock);
    chk("gw_wreq_once", 32'(bus_write_request), 32'd0);
    chk("gw_addr_clr", bus_rw_address, 32'd0);
    wait_resp(1, 600);
    chk("gw_resp", qbyte(0), 32'h06);
    wait_idle("gw_busy_low");

    // framing error on A2
    act0 = act_n;
    rxq.delete();
    txc.delete();
    send_byte(8'h52, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    wait_resp(1, 600);
    chk("fe_resp", qbyte(0), 32'h15);
    wait_idle("fe_busy_low");
    chk("fe_act", 32'(act_n - act0), 32'd0);
    chk("fe_nresp", 32'(rxq.size()), 32'd1);

    // short low glitch on rx is not a start bit
    rxq.delete();
    uart_rx = 1'b0;
    repeat (3) @(negedge clock);
    uart_rx = 1'b1;
    repeat (60) @(negedge clock);
    chk("gl_busy", 32'(bridge_busy), 32'd0);
    chk("gl_nresp", 32'(rxq.size()), 32'd0);

    // reset mid-WDATA
    rxq.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    chk("mr_busy_pre", 32'(bridge_busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mr_tx", 32'(uart_tx), 32'd1);
    chk("mr_addr", bus_rw_address, 32'd0);
    chk("mr_wdata", bus_wdata, 32'd0);
    chk("mr_mask", 32'(bus_write_mask), 32'd0);
    chk("mr_wreq", 32'(bus_write_request), 32'd0);
    chk("mr_busy", 32'(bridge_busy), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    wr0 = wr_n;
    rxq.delete();
    txc.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    wait_resp(1, 600);
    chk("mr2_resp", qbyte(0), 32'h06);
    wait_idle("mr2_busy_low");
    chk("mr2_wr_cnt", 32'(wr_n - wr0), 32'd1);
    chk("mr2_waddr", w_addr, 32'h0000_0080);
    chk("mr2_wdata", w_data, 32'h1234_5678);

`ifdef UART_BRIDGE_TIMEOUT_EN
    act0 = act_n;
    rxq.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    wait_resp(1, 16 * CPB * 10 + 600);
    chk("to_resp", qbyte(0), 32'h15);
    wait_idle("to_busy_low");
    chk("to_act", 32'(act_n - act0), 32'd0);
`endif

    repeat (10) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
